// File: rtl/prio_pkg.sv
// ---------------------------------------------------------------------------
// prio_pkg
// Shared definitions for the display priority selector:
//   N_CH_DEF / W_DEF : default channel count and magnitude width
//   state_t          : selector FSM states (IDLE, SHOW)
//   chan_lsb()       : LSB position of a channel inside the packed din bus
// ---------------------------------------------------------------------------
package prio_pkg;

    localparam int N_CH_DEF = 3;
    localparam int W_DEF    = 16;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    // Channel ch occupies din[ch*w +: w].
    function automatic int chan_lsb(input int ch, input int w);
        return ch * w;
    endfunction

endpackage

// File: rtl/chan_capture.sv
// ---------------------------------------------------------------------------
// chan_capture
// One source channel: registers the ready level, detects its rising edge and
// captures magnitude/sign on that edge, raising a sticky flag.
// Ports:
//   clk      in  system clock
//   rst      in  synchronous reset, active-low (also clears rdy_q)
//   clear_i  in  drop capture and flag; rdy_q keeps tracking rdy_i
//   rdy_i    in  producer ready level
//   din_i    in  channel magnitude
//   sign_i   in  channel sign (1 = negative)
//   mag_o    out captured magnitude
//   sgn_o    out captured sign
//   flag_o   out channel holds a captured value
// ---------------------------------------------------------------------------
module chan_capture
    import prio_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear_i,
    input  logic         rdy_i,
    input  logic [W-1:0] din_i,
    input  logic         sign_i,
    output logic [W-1:0] mag_o,
    output logic         sgn_o,
    output logic         flag_o
);

    logic         rdy_q;
    logic [W-1:0] mag_q;
    logic         sgn_q;
    logic         flag_q;
    logic         rise;

    assign rise = rdy_i & ~rdy_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rdy_q  <= 1'b0;
            mag_q  <= '0;
            sgn_q  <= 1'b0;
            flag_q <= 1'b0;
        end else begin
            // rdy_q tracks the level even during clear so a level held high
            // across clear cannot produce a late capture.
            rdy_q <= rdy_i;
            if (clear_i) begin
                mag_q  <= '0;
                sgn_q  <= 1'b0;
                flag_q <= 1'b0;
            end else if (rise) begin
                mag_q  <= din_i;
                sgn_q  <= sign_i;
                flag_q <= 1'b1;
            end
        end
    end

    assign mag_o  = mag_q;
    assign sgn_o  = sgn_q;
    assign flag_o = flag_q;

endmodule

// File: rtl/priority_mux_n.sv
// ---------------------------------------------------------------------------
// priority_mux_n
// Captures N_CH sign-magnitude channels on the rising edge of their ready
// levels and drives the display with the highest-index captured channel,
// registered one cycle after capture, plus index, valid and update strobe.
// Ports:
//   clk        in  system clock
//   rst        in  synchronous reset, active-low
//   clear      in  start new operation; drops all captured channels
//   din        in  packed channel magnitudes, channel i = din[i*W +: W]
//   sign_in    in  channel signs (1 = negative)
//   rdy        in  per-channel ready levels
//   dout       out displayed magnitude
//   sign_out   out displayed sign
//   sel_idx    out index of displayed channel
//   dout_valid out at least one channel captured
//   upd        out one-cycle pulse when dout/sign_out/sel_idx changed
// ---------------------------------------------------------------------------
module priority_mux_n
    import prio_pkg::*;
#(
    parameter int N_CH  = N_CH_DEF,
    parameter int W     = W_DEF,
    parameter int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [N_CH*W-1:0] din,
    input  logic [N_CH-1:0]   sign_in,
    input  logic [N_CH-1:0]   rdy,
    output logic [W-1:0]      dout,
    output logic              sign_out,
    output logic [IDX_W-1:0]  sel_idx,
    output logic              dout_valid,
    output logic              upd
);

    logic [W-1:0]     cap_mag [N_CH];
    logic [N_CH-1:0]  cap_sgn;
    logic [N_CH-1:0]  flag;

    for (genvar g = 0; g < N_CH; g++) begin : g_chan
        localparam int LSB = chan_lsb(g, W);
        chan_capture #(
            .W(W)
        ) u_cap (
            .clk     (clk),
            .rst     (rst),
            .clear_i (clear),
            .rdy_i   (rdy[g]),
            .din_i   (din[LSB +: W]),
            .sign_i  (sign_in[g]),
            .mag_o   (cap_mag[g]),
            .sgn_o   (cap_sgn[g]),
            .flag_o  (flag[g])
        );
    end

    // Winner selection: ascending scan so the highest flagged index wins.
    // With no flags the winner is all-zero, which keeps IDLE outputs at 0.
    logic [W-1:0]     mag_d;
    logic             sgn_d;
    logic [IDX_W-1:0] idx_d;
    logic             any_flag;
    logic             changed_d;

    always_comb begin
        mag_d = '0;
        sgn_d = 1'b0;
        idx_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (flag[i]) begin
                mag_d = cap_mag[i];
                sgn_d = cap_sgn[i];
                idx_d = IDX_W'(i);
            end
        end
    end

    assign any_flag = |flag;

    logic [W-1:0]     dout_q;
    logic             sign_q;
    logic [IDX_W-1:0] idx_q;
    logic             valid_q;
    logic             upd_q;
    state_t           state_q;

    assign changed_d = (mag_d != dout_q) || (sgn_d != sign_q) || (idx_d != idx_q);

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            state_q <= IDLE;
            dout_q  <= '0;
            sign_q  <= 1'b0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            upd_q   <= 1'b0;
        end else begin
            dout_q <= mag_d;
            sign_q <= sgn_d;
            idx_q  <= idx_d;
            upd_q  <= changed_d;
            case (state_q)
                IDLE: begin
                    valid_q <= any_flag;
                    if (any_flag) begin
                        state_q <= SHOW;
                    end
                end
                SHOW: begin
                    valid_q <= 1'b1;
                end
            endcase
        end
    end

    assign dout       = dout_q;
    assign sign_out   = sign_q;
    assign sel_idx    = idx_q;
    assign dout_valid = valid_q;
    assign upd        = upd_q;

endmodule

// File: doc/priority_mux_n.md
Name: priority_mux_n

Overview:
Parametrised successor of the display priority selector. It accepts N_CH sign-magnitude operand/result channels from the calculator datapath, each with a ready level. Each channel's value is captured on the rising edge of its ready. The block drives the display path with the highest-priority captured channel, registered, plus a selection index and an update strobe for the display refresh logic.

Parameters:
N_CH, 3, number of source channels; channel N_CH-1 has the highest priority (product)
W, 16, magnitude width per channel
IDX_W, $clog2(N_CH) (min 1), width of the selection index

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low
clear  in  1  synchronous start-new-operation; drops all captured channels
din  in  N_CH*W  channel magnitudes; channel i = din[i*W +: W]
sign_in  in  N_CH  channel sign bits (1 = negative)
rdy  in  N_CH  per-channel ready levels (sticky from producer)
dout  out  W  displayed magnitude
sign_out  out  1  displayed sign
sel_idx  out  IDX_W  index of displayed channel
dout_valid  out  1  at least one channel captured
upd  out  1  one-cycle pulse when dout/sign_out/sel_idx changed

Behaviour:
- Reset: clk rising edge with rst=0 sets all captured regs, sticky flags, rdy_q, and all outputs to 0. FSM goes to IDLE.
- Edge detect: rdy_q <= rdy every cycle. rise[i] = rdy[i] & ~rdy_q[i].
- Capture:
  - At the edge where rise[i]=1, cap_mag[i] <= din slice and cap_sgn[i] <= sign_in[i]. Set flag[i] <= 1.
  - Changes of din while rdy stays high are ignored until the next rise.
- Channel held high through reset: rdy_q is 0 after reset, so the channel captures on the first edge after rst returns to 1.
- Selection (combinational on flags): winner = highest i with flag[i]=1.
- Output registers:
  - At the edge after a flag or capture update, dout/sign_out/sel_idx load the winner's captured values.
  - Latency: rdy rise sampled at edge k means the output is valid at edge k+1.
- upd: pulses for exactly one cycle at the edge where any of dout/sign_out/sel_idx loads a value different from its previous value. No pulse if the loaded values are identical.
- FSM:
  - IDLE: dout_valid=0, outputs hold 0. Goes to SHOW when any flag is set.
  - SHOW: dout_valid=1. Goes to IDLE on clear.
- Lower-priority rise while a higher channel is flagged: internal capture updates, outputs unchanged, no upd.
- Re-rise of the selected channel: new value displayed at k+1; upd pulses only if the value differs.
- clear:
  - At the edge with clear=1, flags, cap regs, outputs, dout_valid, and upd are zeroed; FSM goes to IDLE.
  - rdy_q still updates, so levels held high do not re-capture.
  - A rise coinciding with clear is discarded; clear has precedence.
- Reset mid-operation behaves like clear but also zeroes rdy_q.
- Simultaneous rises on several channels: all are captured; the highest index is displayed.
- Width: no arithmetic. Magnitude is passed through unmodified; the sign is carried separately. A zero magnitude with sign 1 is displayed as-is (no normalisation).

Decomposition:
- Package prio_pkg: default N_CH/W, the IDLE/SHOW state enum, and the channel slice helper function.
- Sub-module chan_capture: one per channel via generate; contains rdy_q, rise detection, cap_mag, cap_sgn, flag, and the clear/reset handling.
- Priority encode, output registers, and FSM stay in the top level.

Test Plan:
- Reset with rst=0 for 2 cycles, rdy=0 -> dout=0, sign_out=0, sel_idx=0, dout_valid=0, upd=0.
- Sequence: din ch0=15 sign 0 with rdy0 rise, then ch1=10 sign 1 with rdy1, then ch2=150 sign 1 with rdy2, one rise every 10 cycles -> display 15/+, then 10/−, then 150/−. sel_idx 0→1→2, one upd per step, each 1 cycle after the rise.
- With ch2=150 displayed, rdy0 falls and rises with din ch0=99 -> outputs stay 150/2, no upd. After clear then a new rdy0 rise, 99 is displayed.
- clear and rdy1 rise on the same edge -> flags 0, dout_valid=0, no capture. rdy1 held high -> no capture until it falls and rises again.
- rdy2 high during reset, din ch2=150 -> capture on first edge after rst release, dout=150 one cycle later.
- rdy0 and rdy1 rise on the same edge with values 7 and 8 -> display 8, sel_idx=1, single upd.
